sr_ff_monitor: RTL and testbench

SR_FF_MONITOR -- requirements
Module: sr_ff_monitor

---
 rtl/sr_mon_pkg.sv | 23 ++
 rtl/sr_ff_monitor_sat_counter.sv | 21 ++
 rtl/sr_ff_monitor.sv | 110 +++++++++++
 tb/tb_sr_ff_monitor.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/sr_mon_pkg.sv
// Shared types for the SR flip-flop monitor: model states, check result codes, default counter width.
// Pure declarations; no clocked logic lives here.
package sr_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRACK   = 2'd1,
        ST_ILLEGAL = 2'd2
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISMATCH = 2'b01;
    localparam logic [1:0] ERR_COMPL    = 2'b10;
    localparam logic [1:0] ERR_BOTH     = 2'b11;

    localparam int DEF_CNT_W = 8;

    // bit0: q disagrees with the model; bit1: q and qb are not complementary
    function automatic logic [1:0] chk_code(input logic q, input logic qb, input logic exp_q);
        return {qb == q, q != exp_q};
    endfunction

endpackage

// File: rtl/sr_ff_monitor_sat_counter.sv
// Saturating event counter with synchronous reset and clear.
// Latency: count reflects an inc on the following edge. No backpressure; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/sr_ff_monitor.sv
// Shadow model of an SR flip-flop that checks the observed q/qb one cycle after each stimulus.
// Latency: one edge from sample to check, fully pipelined. No backpressure; every sample is accepted.
module sr_ff_monitor
    import sr_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             qb,
    input  logic             clr,
    output logic             exp_q,
    output logic             model_valid,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [1:0]       first_err,
    output logic             illegal_pulse,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] ill_cnt
);

    state_e     state;
    state_e     state_nx;
    logic       exp_nx;
    logic       chk_pend;
    logic [1:0] code;
    logic       chk_err;
    logic       ill_evt;

    always_comb begin
        state_nx = state;
        exp_nx   = exp_q;
        if (sample_en) begin
            case ({s, r})
                2'b10: begin
                    state_nx = ST_TRACK;
                    exp_nx   = 1'b1;
                end
                2'b01: begin
                    state_nx = ST_TRACK;
                    exp_nx   = 1'b0;
                end
                2'b11: state_nx = ST_ILLEGAL;
                default: ;
            endcase
        end
    end

    // exp_q already holds the value scheduled alongside chk_pend, so the check needs no extra staging
    assign code        = chk_code(q, qb, exp_q);
    assign chk_err     = chk_pend && (code != ERR_NONE);
    assign ill_evt     = sample_en && s && r;
    assign model_valid = (state == ST_TRACK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            exp_q         <= 1'b0;
            chk_pend      <= 1'b0;
            err_pulse     <= 1'b0;
            illegal_pulse <= 1'b0;
        end else begin
            state         <= state_nx;
            exp_q         <= exp_nx;
            chk_pend      <= sample_en && (state_nx == ST_TRACK);
            err_pulse     <= chk_err;
            illegal_pulse <= ill_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_sticky <= 1'b0;
            first_err  <= ERR_NONE;
        end else if (chk_err && !err_sticky) begin
            err_sticky <= 1'b1;
            first_err  <= code;
        end
    end

    sat_counter #(.W(CNT_W)) u_chk_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (chk_pend),
        .count (chk_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (chk_err),
        .count (err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_ill_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (ill_evt),
        .count (ill_cnt)
    );

endmodule

// File: tb/tb_sr_ff_monitor.sv
// Vector-table bench for sr_ff_monitor: a wide-counter instance and a 2-bit-counter instance share stimulus.
module tb_sr_ff_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, sample_en, s, r, q, qb, clr;

    logic       exp_q_a, mv_a, ep_a, es_a, ip_a;
    logic [1:0] fe_a;
    logic [7:0] cc_a, ec_a, ic_a;

    logic       exp_q_b, mv_b, ep_b, es_b, ip_b;
    logic [1:0] fe_b;
    logic [1:0] cc_b, ec_b, ic_b;

    sr_ff_monitor #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .s(s), .r(r), .q(q), .qb(qb), .clr(clr),
        .exp_q(exp_q_a), .model_valid(mv_a), .err_pulse(ep_a), .err_sticky(es_a),
        .first_err(fe_a), .illegal_pulse(ip_a), .chk_cnt(cc_a), .err_cnt(ec_a), .ill_cnt(ic_a)
    );

    sr_ff_monitor #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .sample_en(sample_en), .s(s), .r(r), .q(q), .qb(qb), .clr(clr),
        .exp_q(exp_q_b), .model_valid(mv_b), .err_pulse(ep_b), .err_sticky(es_b),
        .first_err(fe_b), .illegal_pulse(ip_b), .chk_cnt(cc_b), .err_cnt(ec_b), .ill_cnt(ic_b)
    );

    // Inputs driven before an edge, and the outputs expected just after it
    typedef struct {
        logic       rst, clr, en, s, r, q, qb;
        logic       eq, mv, ep, es;
        logic [1:0] fe;
        logic       ip;
        int         cc, ec, ic;
    } vec_t;

    vec_t tbl  [18];
    vec_t tbl2 [7];
    int   dut_cc_exp [7];
    vec_t sb [$];

    int n_chk = 0;
    int n_err = 0;

    function automatic vec_t mk(input logic rst_i, clr_i, en_i, s_i, r_i, q_i, qb_i,
                                input logic eq_i, mv_i, ep_i, es_i, input logic [1:0] fe_i,
                                input logic ip_i, input int cc_i, ec_i, ic_i);
        vec_t v;
        v.rst = rst_i; v.clr = clr_i; v.en = en_i; v.s = s_i; v.r = r_i; v.q = q_i; v.qb = qb_i;
        v.eq = eq_i; v.mv = mv_i; v.ep = ep_i; v.es = es_i; v.fe = fe_i; v.ip = ip_i;
        v.cc = cc_i; v.ec = ec_i; v.ic = ic_i;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s row %0d: got %0d, want %0d", nm, row, act, want);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; clr = v.clr; sample_en = v.en; s = v.s; r = v.r; q = v.q; qb = v.qb;
    endtask

    initial begin
        vec_t e;
        rst = 1'b1; clr = 1'b0; sample_en = 1'b0; s = 1'b0; r = 1'b0; q = 1'b0; qb = 1'b1;

        //             rst clr en s r q qb    eq mv ep es fe    ip cc ec ic
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 1, 0, 0, 1,   1, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0, 2'b00, 0, 1, 0, 0);
        tbl[3]  = mk(0, 0, 1, 0, 1, 1, 0,   0, 1, 0, 0, 2'b00, 0, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 1, 0,   0, 1, 1, 1, 2'b01, 0, 2, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 1, 2'b01, 0, 2, 1, 0);
        tbl[6]  = mk(0, 0, 1, 0, 0, 0, 1,   0, 1, 0, 1, 2'b01, 0, 2, 1, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 1, 1,   0, 1, 1, 1, 2'b01, 0, 3, 2, 0);
        tbl[8]  = mk(0, 0, 1, 1, 1, 0, 1,   0, 0, 0, 1, 2'b01, 1, 3, 2, 1);
        tbl[9]  = mk(0, 0, 1, 0, 0, 0, 1,   0, 0, 0, 1, 2'b01, 0, 3, 2, 1);
        tbl[10] = mk(0, 0, 1, 1, 0, 0, 1,   1, 1, 0, 1, 2'b01, 0, 3, 2, 1);
        tbl[11] = mk(0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 1, 2'b01, 0, 4, 2, 1);
        tbl[12] = mk(0, 0, 1, 0, 1, 1, 0,   0, 1, 0, 1, 2'b01, 0, 4, 2, 1);
        tbl[13] = mk(0, 1, 0, 0, 0, 1, 0,   0, 1, 1, 0, 2'b00, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        tbl[15] = mk(0, 0, 1, 1, 0, 0, 0,   1, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        tbl[16] = mk(1, 0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        // Back-to-back mismatching samples: 2-bit counters must stop at 3
        tbl2[0] = mk(1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        tbl2[1] = mk(0, 0, 1, 1, 0, 0, 1,   1, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        tbl2[2] = mk(0, 0, 1, 1, 0, 0, 1,   1, 1, 1, 1, 2'b01, 0, 1, 1, 0);
        tbl2[3] = mk(0, 0, 1, 1, 0, 0, 1,   1, 1, 1, 1, 2'b01, 0, 2, 2, 0);
        tbl2[4] = mk(0, 0, 1, 1, 0, 0, 1,   1, 1, 1, 1, 2'b01, 0, 3, 3, 0);
        tbl2[5] = mk(0, 0, 1, 1, 0, 0, 1,   1, 1, 1, 1, 2'b01, 0, 3, 3, 0);
        tbl2[6] = mk(0, 0, 0, 0, 0, 0, 1,   1, 1, 1, 1, 2'b01, 0, 3, 3, 0);
        dut_cc_exp = '{0, 0, 1, 2, 3, 4, 5};

        @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i]);
            sb.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk("exp_q",         i, exp_q_a, e.eq);
            chk("model_valid",   i, mv_a,    e.mv);
            chk("err_pulse",     i, ep_a,    e.ep);
            chk("err_sticky",    i, es_a,    e.es);
            chk("first_err",     i, fe_a,    e.fe);
            chk("illegal_pulse", i, ip_a,    e.ip);
            chk("chk_cnt",       i, cc_a,    e.cc);
            chk("err_cnt",       i, ec_a,    e.ec);
            chk("ill_cnt",       i, ic_a,    e.ic);
        end

        for (int i = 0; i < 7; i++) begin
            drive(tbl2[i]);
            sb.push_back(tbl2[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk("sat exp_q",     i, exp_q_b, e.eq);
            chk("sat err_pulse", i, ep_b,    e.ep);
            chk("sat first_err", i, fe_b,    e.fe);
            chk("sat chk_cnt",   i, cc_b,    e.cc);
            chk("sat err_cnt",   i, ec_b,    e.ec);
            chk("sat ill_cnt",   i, ic_b,    e.ic);
            chk("wide chk_cnt",  i, cc_a,    dut_cc_exp[i]);
        end

        chk("scoreboard drained", 0, sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
